// File: rtl/alu_result_framer_if.sv
// ============================================================================
//  Module      : alu_result_framer_if
//  Description : Result-in / byte-out bundle between the ALU/comparator
//                result source, the framer and the UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_result_framer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RES_BYTES  = 2
);
    logic [RES_BYTES*DATA_WIDTH-1:0] RES_DATA;
    logic                            RES_VLD;
    logic                            RES_SHORT;
    logic                            TX_BUSY;
    logic [DATA_WIDTH-1:0]           TX_P_DATA;
    logic                            TX_D_VLD;
    logic                            FRM_BUSY;
    logic                            OVF_ERR;

    // Result source and UART side
    modport master (
        output RES_DATA, RES_VLD, RES_SHORT, TX_BUSY,
        input  TX_P_DATA, TX_D_VLD, FRM_BUSY, OVF_ERR
    );

    // Framer side
    modport slave (
        input  RES_DATA, RES_VLD, RES_SHORT, TX_BUSY,
        output TX_P_DATA, TX_D_VLD, FRM_BUSY, OVF_ERR
    );
endinterface

`default_nettype wire

// File: rtl/alu_result_framer.sv
// ============================================================================
//  Module      : alu_result_framer
//  Description : Captures ALU/comparator results and sends them LSB byte
//                first to the UART transmitter, with a one-entry holding
//                buffer for a result arriving mid-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int RES_BYTES  = 2
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    alu_result_framer_if.slave bus
);

    localparam int RES_WIDTH = RES_BYTES * DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(RES_BYTES + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                 state_q;
    logic [RES_WIDTH-1:0]   shift_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [RES_WIDTH-1:0]   buf_data_q;
    logic                   buf_short_q;
    logic                   buf_full_q;
    logic [DATA_WIDTH-1:0]  tx_data_q;
    logic                   tx_vld_q;
    logic                   ovf_q;

    logic [CNT_WIDTH-1:0]   new_cnt_d;
    logic [CNT_WIDTH-1:0]   buf_cnt_d;

    // Byte counts for an incoming result and for the buffered result
    always_comb begin
        new_cnt_d = bus.RES_SHORT ? CNT_WIDTH'(1) : CNT_WIDTH'(RES_BYTES);
        buf_cnt_d = buf_short_q   ? CNT_WIDTH'(1) : CNT_WIDTH'(RES_BYTES);
    end

    // Framing FSM, holding buffer and registered TX/overflow outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            buf_data_q  <= '0;
            buf_short_q <= 1'b0;
            buf_full_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_vld_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            tx_vld_q <= 1'b0;
            ovf_q    <= 1'b0;

            // A result arriving mid-frame is parked, or dropped if the slot is taken
            if (bus.RES_VLD && (state_q != S_IDLE)) begin
                if (!buf_full_q) begin
                    buf_data_q  <= bus.RES_DATA;
                    buf_short_q <= bus.RES_SHORT;
                    buf_full_q  <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.RES_VLD) begin
                        shift_q <= bus.RES_DATA;
                        cnt_q   <= new_cnt_d;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!bus.TX_BUSY) begin
                        tx_data_q <= shift_q[DATA_WIDTH-1:0];
                        tx_vld_q  <= 1'b1;
                        state_q   <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (bus.TX_BUSY) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.TX_BUSY) begin
                        shift_q <= shift_q >> DATA_WIDTH;
                        cnt_q   <= cnt_q - CNT_WIDTH'(1);
                        if (cnt_q > CNT_WIDTH'(1)) begin
                            state_q <= S_ISSUE;
                        end else if (buf_full_q) begin
                            // Older buffered result goes first; overrides the park above
                            shift_q    <= buf_data_q;
                            cnt_q      <= buf_cnt_d;
                            buf_full_q <= 1'b0;
                            state_q    <= S_ISSUE;
                        end else if (bus.RES_VLD) begin
                            // Result parked this edge is promoted at once
                            shift_q    <= bus.RES_DATA;
                            cnt_q      <= new_cnt_d;
                            buf_full_q <= 1'b0;
                            state_q    <= S_ISSUE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.TX_P_DATA = tx_data_q;
    assign bus.TX_D_VLD  = tx_vld_q;
    assign bus.OVF_ERR   = ovf_q;
    assign bus.FRM_BUSY  = (state_q != S_IDLE) || buf_full_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_framer.sv
// ============================================================================
//  Module      : tb_alu_result_framer
//  Description : Scoreboard bench for alu_result_framer with a fake UART
//                transmitter and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_framer;

    localparam int DW = 8;
    localparam int RB = 2;
    localparam int RW = DW * RB;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [RW-1:0] res_data   = '0;
    logic          res_vld    = 1'b0;
    logic          res_short  = 1'b0;
    logic          resp_busy  = 1'b0;
    logic          force_busy = 1'b0;
    logic          cmp_next   = 1'b0;
    logic          chk_en     = 1'b0;

    alu_result_framer_if #(.DATA_WIDTH(DW), .RES_BYTES(RB)) bus ();

    assign bus.RES_DATA  = res_data;
    assign bus.RES_VLD   = res_vld;
    assign bus.RES_SHORT = res_short;
    assign bus.TX_BUSY   = resp_busy | force_busy;

    alu_result_framer #(.DATA_WIDTH(DW), .RES_BYTES(RB)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int ovf_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results in flight (bytes left each), expected byte stream
    int          acc[$];
    logic [DW-1:0] exp_bytes[$];
    logic        exp_ovf = 1'b0;

    always @(posedge CLK) begin
        int n;
        if (RST) begin
            acc.delete();
            exp_bytes.delete();
            exp_ovf = 1'b0;
        end else begin
            exp_ovf = 1'b0;
            if (res_vld) begin
                // One frame in flight plus one parked result is the capacity
                if (acc.size() >= 2) begin
                    exp_ovf = 1'b1;
                end else begin
                    n = res_short ? 1 : RB;
                    acc.push_back(n);
                    for (int i = 0; i < n; i++) exp_bytes.push_back(res_data[i*DW +: DW]);
                end
            end
            if (cmp_next && acc.size() > 0) begin
                acc[0] = acc[0] - 1;
                if (acc[0] == 0) void'(acc.pop_front());
            end
        end
    end

    // Fake UART: acknowledges each strobe with a random busy window
    initial begin
        forever begin
            @(negedge CLK);
            cmp_next = 1'b0;
            if (bus.TX_D_VLD && !RST) begin
                repeat ($urandom_range(0, 2)) @(negedge CLK);
                resp_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge CLK);
                resp_busy = 1'b0;
                cmp_next  = 1'b1;
            end
        end
    end

    // Monitor: compares every strobe and status output against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            if (bus.TX_D_VLD) begin
                if (exp_bytes.size() == 0) check("tx_strobe_unexpected", 32'd1, 32'd0);
                else check("tx_byte", {24'd0, bus.TX_P_DATA}, {24'd0, exp_bytes.pop_front()});
            end
            if (bus.OVF_ERR) ovf_seen++;
            check("ovf_err", {31'd0, bus.OVF_ERR}, {31'd0, exp_ovf});
            check("frm_busy", {31'd0, bus.FRM_BUSY}, {31'd0, (acc.size() > 0)});
        end
    end

    task automatic pulse(input logic [RW-1:0] d, input logic s);
        res_data  = d;
        res_short = s;
        res_vld   = 1'b1;
        @(negedge CLK);
        res_vld   = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((acc.size() != 0 || resp_busy) && k < 500) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 500) check("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        logic seen;
        int   ovf0;
        int   k;

        // Reset state
        #1;
        check("rst_tx_data", {24'd0, bus.TX_P_DATA}, 32'd0);
        check("rst_tx_vld",  {31'd0, bus.TX_D_VLD},  32'd0);
        check("rst_frm_busy",{31'd0, bus.FRM_BUSY},  32'd0);
        check("rst_ovf",     {31'd0, bus.OVF_ERR},   32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk_en = 1'b1;

        // Full result: strobe two cycles after the capture strobe
        pulse(16'hA55A, 1'b0);
        check("lat_early",  {31'd0, bus.TX_D_VLD}, 32'd0);
        @(negedge CLK);
        check("lat_strobe", {31'd0, bus.TX_D_VLD}, 32'd1);
        wait_idle();

        // Comparator result: low byte only
        pulse(16'h0003, 1'b1);
        wait_idle();

        // UART busy when issue is due: strobe held off
        force_busy = 1'b1;
        pulse(16'h3C4B, 1'b0);
        seen = 1'b0;
        repeat (5) begin
            if (bus.TX_D_VLD) seen = 1'b1;
            @(negedge CLK);
        end
        check("hold_no_strobe", {31'd0, seen}, 32'd0);
        force_busy = 1'b0;
        @(negedge CLK);
        check("hold_release_strobe", {31'd0, bus.TX_D_VLD}, 32'd1);
        wait_idle();

        // Second result arrives mid-frame: buffered, no overflow
        ovf0 = ovf_seen;
        pulse(16'h1111, 1'b0);
        repeat (3) @(negedge CLK);
        pulse(16'h2222, 1'b0);
        wait_idle();
        check("buffered_no_ovf", ovf_seen - ovf0, 32'd0);

        // Three back-to-back: third dropped with one overflow pulse
        ovf0 = ovf_seen;
        pulse(16'hBEEF, 1'b0);
        pulse(16'h4321, 1'b0);
        pulse(16'h9999, 1'b0);
        wait_idle();
        check("overflow_once", ovf_seen - ovf0, 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) pulse(RW'($urandom), 1'($urandom));
            else @(negedge CLK);
        end
        wait_idle();
        check("drain_empty", exp_bytes.size(), 32'd0);

        // Reset during the completion wait of the first byte
        pulse(16'hC35A, 1'b0);
        k = 0;
        while (!resp_busy && k < 50) begin
            @(posedge CLK);
            k++;
        end
        if (k >= 50) check("busy_timeout", 32'd1, 32'd0);
        #1;
        chk_en = 1'b0;
        RST = 1'b1;
        #1;
        check("arst_tx_data", {24'd0, bus.TX_P_DATA}, 32'd0);
        check("arst_tx_vld",  {31'd0, bus.TX_D_VLD},  32'd0);
        check("arst_frm_busy",{31'd0, bus.FRM_BUSY},  32'd0);
        check("arst_ovf",     {31'd0, bus.OVF_ERR},   32'd0);
        repeat (8) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk_en = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            if (bus.TX_D_VLD) seen = 1'b1;
            @(negedge CLK);
        end
        check("post_rst_quiet", {31'd0, seen}, 32'd0);

        // Normal operation resumes after reset
        pulse(16'h5AA5, 1'b0);
        wait_idle();
        check("final_drain", exp_bytes.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
